uart_tx_feeder: RTL and testbench

// Byte buffer and sequencer directly upstream of the UART transmit driver. Accepts bytes from the

---
 rtl/uart_tx_feeder.sv | 141 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: 16-entry byte FIFO feeding a UART transmit driver one byte at a time.
// Latency: a write into an empty FIFO while idle raises data_en three clock edges later
//   (count update, LOAD, SEND). After each frame the FSM waits GAP_CYCLES clocks in GAP,
//   then spends one LOAD cycle before the next byte is presented.
// Backpressure: writes to a full FIFO are dropped and set the sticky overflow flag. The
//   exception is a write in the same cycle as a pop, which is accepted.
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   wr_en, wr_data           host byte write; one byte per cycle
//   full, empty, fifo_count  FIFO occupancy status, registered
//   overflow, ovf_clr        sticky dropped-write flag and its clear; the clear wins
//   uart_data, data_en       byte presented to the driver; uart_data is held while data_en=1
//   tx_frame_done            one-cycle pulse from the driver when the frame completes
//   tx_busy                  high in LOAD, SEND or GAP
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DATA_W-1:0]     uart_data,
  output logic                  data_en,
  input  logic                  tx_frame_done,
  output logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [GW-1:0]         GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]         GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_W-1:0]       uart_data_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic                    pop, wr_ok, load_en;

  // A pop only happens in SEND, and SEND always owns the head entry, so count cannot underflow.
  assign pop   = (state_q == S_SEND) && tx_frame_done;
  // On a full FIFO, a simultaneous pop frees the slot that the write pointer already aims at.
  assign wr_ok = wr_en && ((count_q != CNT_FULL) || pop);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr)
      overflow_d = 1'b0;
    else if (wr_en && !wr_ok)
      overflow_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    load_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_frame_done) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = (count_q != '0) ? S_LOAD : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      uart_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (wr_ok)   wr_ptr_q    <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q    <= rd_ptr_q + PTR_ONE;
      if (load_en) uart_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage needs no reset: the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign uart_data  = uart_data_q;
  assign data_en    = (state_q == S_SEND);
  assign tx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed test of uart_tx_feeder.
// Accepted bytes are pushed to a scoreboard queue and compared against uart_data in order.
// The queue size also serves as the expected fifo_count.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx_frame_done = 1'b0;
  logic       full, empty, overflow, data_en, tx_busy;
  logic [4:0] fifo_count;
  logic [7:0] uart_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  uart_tx_feeder #(.DEPTH_LOG2(4), .DATA_W(8), .GAP_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .fifo_count(fifo_count), .overflow(overflow),
    .ovf_clr(ovf_clr), .uart_data(uart_data), .data_en(data_en),
    .tx_frame_done(tx_frame_done), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one byte. It is pushed to the scoreboard only if the model has room for it.
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    if (sb.size() < 16) sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_data_en();
    int n = 0;
    while (data_en !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("data_en_timeout", {31'd0, data_en}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  // Wait for the presented byte, check it against the scoreboard head, then pulse done.
  task automatic send_one(input string tag);
    logic [7:0] exp;
    wait_data_en();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      exp = 8'h00;
    end else begin
      exp = sb.pop_front();
    end
    chk({tag, "_byte"}, {24'd0, uart_data}, {24'd0, exp});
    tx_frame_done = 1'b1;
    tick();
    tx_frame_done = 1'b0;
    chk({tag, "_count"}, {27'd0, fifo_count}, sb.size());
    chk({tag, "_data_en_low"}, {31'd0, data_en}, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_uart_data", {24'd0, uart_data}, 32'd0);
    chk("rst_data_en", {31'd0, data_en}, 32'd0);
    chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // 1: single byte and its latency. The write edge counts, then LOAD, then SEND.
    wr(8'hA5);
    chk("t1_count_after_wr", {27'd0, fifo_count}, 32'd1);
    chk("t1_data_en_e1", {31'd0, data_en}, 32'd0);
    tick();
    chk("t1_data_en_e2", {31'd0, data_en}, 32'd0);
    chk("t1_busy_load", {31'd0, tx_busy}, 32'd1);
    tick();
    chk("t1_data_en_e3", {31'd0, data_en}, 32'd1);
    send_one("t1");
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_busy_gap", {31'd0, tx_busy}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    chk("t1_busy_gap_end", {31'd0, tx_busy}, 32'd1);
    tick();
    chk("t1_idle_after_16", {31'd0, tx_busy}, 32'd0);

    // 2: fill to full, then drop one write; drain in order
    for (int i = 1; i <= 16; i++) wr(8'(i));
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_count16", {27'd0, fifo_count}, 32'd16);
    chk("t2_ovf_before", {31'd0, overflow}, 32'd0);
    wr(8'hFF);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    chk("t2_count_after_drop", {27'd0, fifo_count}, 32'd16);
    for (int i = 0; i < 16; i++) send_one("t2");
    chk("t2_drained_empty", {31'd0, empty}, 32'd1);
    wait_idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t2_ovf_cleared", {31'd0, overflow}, 32'd0);

    // 3: full FIFO, write and pop in the same cycle
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
    wait_data_en();
    chk("t3_full_before", {31'd0, full}, 32'd1);
    chk("t3_head", {24'd0, uart_data}, {24'd0, sb.pop_front()});
    wr_en = 1'b1;
    wr_data = 8'hC3;
    tx_frame_done = 1'b1;
    sb.push_back(8'hC3);
    tick();
    wr_en = 1'b0;
    tx_frame_done = 1'b0;
    chk("t3_count16", {27'd0, fifo_count}, 32'd16);
    chk("t3_no_overflow", {31'd0, overflow}, 32'd0);
    chk("t3_full_after", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) send_one("t3");
    wait_idle();

    // 4: data_en stays low for 16 GAP cycles plus one LOAD cycle
    wr(8'h55);
    wr(8'h66);
    send_one("t4a");
    n = 1;
    while (data_en !== 1'b1 && n < 64) begin
      tick();
      if (data_en !== 1'b1) n++;
    end
    chk("t4_low_cycles", n, 32'd17);
    send_one("t4b");
    wait_idle();

    // 5: done ignored in IDLE and GAP; ovf_clr beats a simultaneous drop
    tx_frame_done = 1'b1;
    tick();
    tx_frame_done = 1'b0;
    chk("t5_idle_count", {27'd0, fifo_count}, 32'd0);
    chk("t5_idle_busy", {31'd0, tx_busy}, 32'd0);
    wr(8'h11);
    wr(8'h22);
    send_one("t5a");
    tx_frame_done = 1'b1;
    tick();
    tx_frame_done = 1'b0;
    chk("t5_gap_count", {27'd0, fifo_count}, 32'd1);
    chk("t5_gap_data_en", {31'd0, data_en}, 32'd0);
    send_one("t5b");
    wait_idle();
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    wr_en = 1'b1;
    wr_data = 8'hEE;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_clr_wins", {31'd0, overflow}, 32'd0);
    chk("t5_clr_count", {27'd0, fifo_count}, 32'd16);
    tick();
    wr_en = 1'b0;
    chk("t5_drop_sets", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_clr_alone", {31'd0, overflow}, 32'd0);

    // 6: asynchronous reset during SEND with 5 bytes queued
    for (int i = 0; i < 11; i++) send_one("t6_drain");
    wait_data_en();
    chk("t6_count5", {27'd0, fifo_count}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data_en", {31'd0, data_en}, 32'd0);
    chk("t6_count", {27'd0, fifo_count}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_busy", {31'd0, tx_busy}, 32'd0);
    sb.delete();
    tick();
    #2 rst_n = 1'b1;
    tick();
    wr(8'h7E);
    send_one("t6_after");
    wait_idle();
    chk("t6_final_empty", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
